block_feeder: RTL and testbench
===============================

Name: block_feeder

Overview:
- Writer end of blockStoreIfc; peer of the block-storage reader.
- Accepts a full 352-bit block (initial state) from the host/loader side and buffers it.
- Serializes the block into 44 8-bit chunks, MSB chunk first, once the reader signals writeReady.
- Sits between the host input path and block storage; keeps exactly one block in flight (two with prefetch).

Parameters:
- BLOCK_W, 352, block width in bits.
- CHUNK_W, 8, width of blockData per transfer.
- NUM_CHUNKS, BLOCK_W/CHUNK_W = 44, chunks per block; BLOCK_W must be an exact multiple of CHUNK_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  host presents a block on in_block.
- in_block  input  BLOCK_W  block data; bits [351:344] are chunk 0.
- in_ready  output  1  feeder can accept a block this cycle.
- blkWr  modport  blockStoreIfc.writer  carries writeReady (in, 1), writeValid (out, 1), blockData (out, CHUNK_W).
- blocks_sent  output  16  count of completed block bursts, wraps at 65535->0.

Behaviour:
- Reset is asynchronous, active-high. Outputs are cleared immediately, not at the next edge:
  - state=EMPTY, in_ready=1, writeValid=0, blockData=0, blocks_sent=0, chunk counter=0, buffer=0.
- All outputs except in_ready are registered. in_ready is a decode of state.
- A host transfer occurs on an edge where in_valid && in_ready. in_block is captured whole.
- in_valid while in_ready=0 is ignored; the host holds its block until accepted.
- State machine:
  - EMPTY: in_ready=1. On a host transfer, go to LOADED.
  - LOADED: in_ready=0. writeReady is sampled each edge. When it is 1, go to SEND, set chunk=0, and register writeValid=1 with blockData=buf[351:344].
  - SEND: writeValid=1 every cycle. Chunk k = buf[BLOCK_W-1-8k -: 8], driven in cycle start+k, k=0..43, with no gaps or stalls. writeReady is ignored. At the edge ending chunk 43: writeValid<=0, blocks_sent<=blocks_sent+1, go to EMPTY.
- Latency:
  - Host accept at edge t gives LOADED at t+1.
  - writeReady=1 sampled at edge t+1 gives the first chunk visible after edge t+1 (cycle t+1..t+2).
  - Burst length is exactly 44 cycles.
  - A chunk transfers in every cycle writeValid=1. The reader must not back-pressure mid-burst.
- Chunk counter is 6 bits. Its terminal value is NUM_CHUNKS-1; it never exceeds 43.
- blockData holds its last value when writeValid=0.
- Boundaries:
  - writeReady high in EMPTY: no effect.
  - writeReady held high continuously: back-to-back bursts are separated by at least the EMPTY->LOADED refill (2 idle cycles minimum without prefetch).
  - Reset mid-burst: burst aborts at once, writeValid drops asynchronously, and the partially sent block is discarded.
  - blocks_sent 65535 + 1 -> 0.

Optional Feature:
- Macro: BLOCK_FEEDER_PREFETCH_EN.
- Defined:
  - Adds a second BLOCK_W staging register.
  - in_ready=1 whenever the staging register is empty, including during LOADED and SEND.
  - At the last-chunk edge, if staging is full, staging moves to the main buffer and state goes to LOADED, not EMPTY.
  - Simultaneous host accept and last-chunk edge: the staged block is promoted, and the new block fills the freed staging slot in the same edge.
  - Order of blocks is preserved.
- Undefined: single buffer, behaviour exactly as above. No staging logic is synthesized.

Decomposition:
- Package block_feeder_pkg:
  - BLOCK_W, CHUNK_W, NUM_CHUNKS constants (shared with block storage).
  - State enum {EMPTY, LOADED, SEND}.
  - Chunk index typedef (logic [5:0]).
- Sub-module: chunk_serializer. It holds the block buffer and chunk counter and selects blockData. The top module keeps the FSM, the host handshake and blocks_sent.
- Registers use the existing ff primitive with an async-reset variant.

Test Plan:
- Reset, then load in_block=352'h0102...2C (chunk k = k+1), writeReady=1 -> 44 consecutive writeValid cycles with blockData 0x01..0x2C in order, blocks_sent=1, in_ready returns 1.
- Load a block with writeReady=0 for 20 cycles, then 1 -> writeValid stays 0 for those 20 cycles. The burst starts exactly one cycle after writeReady is sampled high.
- Assert rst asynchronously at chunk 17 of a burst -> writeValid=0 and blocks_sent=0 before the next edge, state EMPTY. The next load restarts at chunk 0.
- in_valid pulsed while in_ready=0 (LOADED/SEND) -> block ignored; the output stream is unchanged.
- Force blocks_sent=65535 via 65535 bursts (or preload), then one more burst -> blocks_sent=0.
- With BLOCK_FEEDER_PREFETCH_EN, block B accepted during block A's burst and writeReady held 1 -> B's chunk 0 follows A's chunk 43 after the LOADED cycle, and A/B order is preserved.

Source files
------------

// File: rtl/block_feeder_pkg.sv
// block_feeder_pkg: block geometry, FSM states and chunk index type
// shared between the block feeder and block storage.
package block_feeder_pkg;

    localparam int BLOCK_W    = 352;
    localparam int CHUNK_W    = 8;
    localparam int NUM_CHUNKS = BLOCK_W / CHUNK_W;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        LOADED = 2'd1,
        SEND   = 2'd2
    } state_e;

    typedef logic [5:0] chunk_idx_t;

    localparam chunk_idx_t LAST_CHUNK = chunk_idx_t'(NUM_CHUNKS - 1);

    // Chunk idx of a block, chunk 0 being the most significant byte.
    function automatic logic [CHUNK_W-1:0] chunk_of(
        input logic [BLOCK_W-1:0] blk,
        input chunk_idx_t         idx
    );
        logic [BLOCK_W-1:0] sh;
        sh = blk << (int'(idx) * CHUNK_W);
        return sh[BLOCK_W-1 -: CHUNK_W];
    endfunction

endpackage

// File: rtl/block_store_ifc.sv
// blockStoreIfc: chunk transfer link between block feeder (writer)
// and block storage (reader).
interface blockStoreIfc;

    logic                                 writeReady;
    logic                                 writeValid;
    logic [block_feeder_pkg::CHUNK_W-1:0] blockData;

    modport writer (
        input  writeReady,
        output writeValid,
        output blockData
    );

    modport reader (
        output writeReady,
        input  writeValid,
        input  blockData
    );

endinterface

// File: rtl/block_feeder_chunk_serializer.sv
// chunk_serializer: holds the block buffer and chunk counter and
// registers the chunk presented on blockData.
module chunk_serializer
    import block_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_block,
    input  logic               start,
    input  logic               advance,
    output logic [CHUNK_W-1:0] data,
    output logic               last
);

    logic [BLOCK_W-1:0] blk_d, blk_q;
    chunk_idx_t         cnt_d, cnt_q;
    logic [CHUNK_W-1:0] data_d, data_q;

    // Buffer capture, counter step and chunk select; data holds otherwise.
    always_comb begin
        blk_d  = blk_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (load) begin
            blk_d = load_block;
        end
        if (start) begin
            cnt_d  = '0;
            data_d = chunk_of(blk_q, chunk_idx_t'(0));
        end else if (advance) begin
            cnt_d  = cnt_q + chunk_idx_t'(1);
            data_d = chunk_of(blk_q, cnt_q + chunk_idx_t'(1));
        end
    end

    ff #(.W(BLOCK_W)) u_blk (.clk(clk), .rst(rst), .d(blk_d), .q(blk_q));
    ff #(.W(6)) u_cnt (.clk(clk), .rst(rst), .d(cnt_d), .q(cnt_q));
    ff #(.W(CHUNK_W)) u_data (.clk(clk), .rst(rst), .d(data_d), .q(data_q));

    assign data = data_q;
    assign last = (cnt_q == LAST_CHUNK);

endmodule

// File: rtl/ff.sv
// ff: generic register with asynchronous active-high reset to zero.
// Every state element of the feeder is built from this primitive.
module ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Plain D register, cleared immediately on rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/block_feeder.sv
// block_feeder: buffers a host block and bursts it as 44 byte chunks.
// Optional prefetch staging slot: define BLOCK_FEEDER_PREFETCH_EN.
module block_feeder
    import block_feeder_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [BLOCK_W-1:0] in_block,
    output logic               in_ready,
    blockStoreIfc.writer       blkWr,
    output logic [15:0]        blocks_sent
);

    logic [1:0]   state_raw;
    state_e       state_q;
    state_e       state_d;
    logic         valid_d, valid_q;
    logic [15:0]  sent_d, sent_q;

    logic               host_xfer;
    logic               ser_load;
    logic [BLOCK_W-1:0] ser_block;
    logic               ser_start;
    logic               ser_advance;
    logic               ser_last;
    logic [CHUNK_W-1:0] ser_data;

`ifdef BLOCK_FEEDER_PREFETCH_EN
    logic [BLOCK_W-1:0] stage_d, stage_q;
    logic               sfull_d, sfull_q;
    logic               promote;
`endif

    assign state_q = state_e'(state_raw);

`ifdef BLOCK_FEEDER_PREFETCH_EN
    assign in_ready = !sfull_q;
`else
    assign in_ready = (state_q == EMPTY);
`endif

    assign host_xfer = in_valid && in_ready;

    // Next-state, burst control and completed-burst count.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        sent_d      = sent_q;
        ser_load    = 1'b0;
        ser_block   = in_block;
        ser_start   = 1'b0;
        ser_advance = 1'b0;
`ifdef BLOCK_FEEDER_PREFETCH_EN
        promote     = 1'b0;
`endif
        unique case (state_q)
            EMPTY: begin
`ifdef BLOCK_FEEDER_PREFETCH_EN
                if (sfull_q) begin
                    promote   = 1'b1;
                    ser_load  = 1'b1;
                    ser_block = stage_q;
                    state_d   = LOADED;
                end else
`endif
                if (host_xfer) begin
                    ser_load = 1'b1;
                    state_d  = LOADED;
                end
            end
            LOADED: begin
                if (blkWr.writeReady) begin
                    ser_start = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (ser_last) begin
                    valid_d = 1'b0;
                    sent_d  = sent_q + 16'd1;
                    state_d = EMPTY;
`ifdef BLOCK_FEEDER_PREFETCH_EN
                    if (sfull_q) begin
                        promote   = 1'b1;
                        ser_load  = 1'b1;
                        ser_block = stage_q;
                        state_d   = LOADED;
                    end
`endif
                end else begin
                    ser_advance = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = EMPTY;
            end
        endcase
    end

`ifdef BLOCK_FEEDER_PREFETCH_EN
    // Staging slot: freed by promotion, refilled by host accepts
    // made while the main buffer is busy (same edge allowed).
    always_comb begin
        stage_d = stage_q;
        sfull_d = sfull_q;
        if (promote) begin
            sfull_d = 1'b0;
        end
        if (host_xfer && (state_q != EMPTY)) begin
            stage_d = in_block;
            sfull_d = 1'b1;
        end
    end

    ff #(.W(BLOCK_W)) u_stage (.clk(clk), .rst(rst), .d(stage_d), .q(stage_q));
    ff #(.W(1)) u_sfull (.clk(clk), .rst(rst), .d(sfull_d), .q(sfull_q));
`endif

    ff #(.W(2)) u_state (.clk(clk), .rst(rst), .d(state_d), .q(state_raw));
    ff #(.W(1)) u_valid (.clk(clk), .rst(rst), .d(valid_d), .q(valid_q));
    ff #(.W(16)) u_sent (.clk(clk), .rst(rst), .d(sent_d), .q(sent_q));

    chunk_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .load_block (ser_block),
        .start      (ser_start),
        .advance    (ser_advance),
        .data       (ser_data),
        .last       (ser_last)
    );

    assign blkWr.writeValid = valid_q;
    assign blkWr.blockData  = ser_data;
    assign blocks_sent      = sent_q;

endmodule

// File: tb/tb_block_feeder.sv
// tb_block_feeder: directed bursts from a vector table plus reset,
// wrap and (optionally) prefetch sequences for block_feeder.
module tb_block_feeder;
    import block_feeder_pkg::*;

    typedef struct {
        logic [BLOCK_W-1:0] blk;
        int                 wr_delay;
        int                 junk_at;
        logic [15:0]        exp_sent;
    } vec_t;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [BLOCK_W-1:0] in_block;
    logic               in_ready;
    logic [15:0]        blocks_sent;

    blockStoreIfc bif ();

    int n_checks;
    int n_fail;

    block_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_block    (in_block),
        .in_ready    (in_ready),
        .blkWr       (bif),
        .blocks_sent (blocks_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_chunk(input logic [BLOCK_W-1:0] b,
                                             input int k);
        logic [BLOCK_W-1:0] t;
        t = b;
        return t[BLOCK_W-1-8*k -: 8];
    endfunction

    // Called at a negedge; first chunk must show at the next negedge.
    task automatic expect_chunks(input logic [BLOCK_W-1:0] b,
                                 input int junk_at, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("valid_chunk%0d", k), 32'(bif.writeValid), 1);
            check($sformatf("data_chunk%0d", k), 32'(bif.blockData),
                  32'(exp_chunk(b, k)));
`ifndef BLOCK_FEEDER_PREFETCH_EN
            if (k == junk_at) begin
                check("ready_low_in_send", 32'(in_ready), 0);
                in_valid = 1'b1;
                in_block = ~b;
            end
`endif
        end
    endtask

    task automatic run_burst(input vec_t v);
        if (v.wr_delay > 0) bif.writeReady = 1'b0;
        in_valid = 1'b1;
        in_block = v.blk;
        check("ready_empty", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("loaded_no_valid", 32'(bif.writeValid), 0);
`ifndef BLOCK_FEEDER_PREFETCH_EN
        check("ready_low_loaded", 32'(in_ready), 0);
`endif
        for (int d = 0; d < v.wr_delay; d++) begin
            @(negedge clk);
            check("wait_no_valid", 32'(bif.writeValid), 0);
        end
        bif.writeReady = 1'b1;
        expect_chunks(v.blk, v.junk_at, NUM_CHUNKS);
        @(negedge clk);
        in_valid = 1'b0;
        check("end_valid_low", 32'(bif.writeValid), 0);
        check("end_ready", 32'(in_ready), 1);
        check("end_sent", 32'(blocks_sent), 32'(v.exp_sent));
        check("end_data_hold", 32'(bif.blockData),
              32'(exp_chunk(v.blk, NUM_CHUNKS - 1)));
    endtask

    vec_t               vecs[4];
    logic [BLOCK_W-1:0] inc_blk;
    logic [BLOCK_W-1:0] blk_b;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_block = '0;
        bif.writeReady = 1'b0;

        for (int k = 0; k < NUM_CHUNKS; k++) begin
            inc_blk[BLOCK_W-1-8*k -: 8] = 8'(k + 1);
        end
        blk_b = {11{32'hDEADBEEF}};

        vecs[0] = '{inc_blk, 0, -1, 16'd1};
        vecs[1] = '{{44{8'hA5}}, 20, 5, 16'd2};
        vecs[2] = '{~inc_blk, 3, 40, 16'd3};
        vecs[3] = '{blk_b, 0, 0, 16'd4};

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bif.writeValid), 0);
        check("rst_data", 32'(bif.blockData), 0);
        check("rst_sent", 32'(blocks_sent), 0);
        check("rst_ready", 32'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // writeReady stays high across vecs[2]->vecs[3]: back-to-back.
        for (int i = 0; i < 4; i++) begin
            run_burst(vecs[i]);
        end

        // Asynchronous reset in the middle of a burst.
        bif.writeReady = 1'b1;
        in_valid = 1'b1;
        in_block = inc_blk;
        @(negedge clk);
        in_valid = 1'b0;
        expect_chunks(inc_blk, -1, 18);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(bif.writeValid), 0);
        check("arst_sent", 32'(blocks_sent), 0);
        check("arst_ready", 32'(in_ready), 1);
        check("arst_data", 32'(bif.blockData), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_burst('{inc_blk, 0, -1, 16'd1});

        // Wrap of the burst counter from 65535.
        force dut.u_sent.q = 16'hFFFF;
        #1;
        release dut.u_sent.q;
        @(negedge clk);
        check("preload_sent", 32'(blocks_sent), 32'hFFFF);
        run_burst('{blk_b, 2, -1, 16'd0});

`ifdef BLOCK_FEEDER_PREFETCH_EN
        // Block B accepted during A's burst follows after one LOADED cycle.
        bif.writeReady = 1'b1;
        in_valid = 1'b1;
        in_block = inc_blk;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("pf_a_valid", 32'(bif.writeValid), 1);
            check("pf_a_data", 32'(bif.blockData), 32'(exp_chunk(inc_blk, k)));
            if (k == 10) begin
                check("pf_ready_in_send", 32'(in_ready), 1);
                in_valid = 1'b1;
                in_block = blk_b;
            end
        end
        @(negedge clk);
        check("pf_gap", 32'(bif.writeValid), 0);
        check("pf_sent_a", 32'(blocks_sent), 1);
        expect_chunks(blk_b, -1, NUM_CHUNKS);
        @(negedge clk);
        check("pf_end_valid", 32'(bif.writeValid), 0);
        check("pf_sent_b", 32'(blocks_sent), 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
